pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-address generator for the MiniMIPS32 IF stage; successor to the single-cycle PC register. Produces the fetch PC, drives a request/acknowledge handshake to an instruction memory of arbitrary latency, and arbitrates CP0 exception redirects, branch redirects and sequential increment. Redirects that arrive while a fetch cannot be consumed are buffered, not lost. Sits between CTRL/ID/CP0 and the instruction-memory port.

## Interface
- ADDR_W, 32, PC width in bits.
- INIT_PC, 32'hBFC0_0000, reset/boot vector, ADDR_W bits.
- FETCH_N, 1, instructions per fetch (1, 2 or 4); sequential increment = 4*FETCH_N.
- STALL_W, 6, width of the CTRL stall vector.
- cpu_clk_75M  in  1  sole clock; all state updates on posedge.
- cpu_rst_n  in  1  reset, synchronous, active-low (`RstEnable` = 0).
- stall  in  STALL_W  CTRL stall vector; only stall[0] is used.
- branch_flag_i  in  1  branch redirect request from ID.
- branch_target_address_i  in  ADDR_W  branch target.
- cp0_branch_flag  in  1  exception/ERET redirect from CP0.
- cp0_branch_addr  in  ADDR_W  exception/ERET target.
- if_ack  in  1  memory response valid for the current pc; data stays stable while if_req is held.
- pc  out  ADDR_W  current fetch address; stable while a fetch is unconsumed.
- ce  out  1  instruction-memory chip enable.
- if_req  out  1  fetch request for pc.
- inst_valid_o  out  1  response is on the architectural path; IF/ID must latch it.
- adel_o  out  1  one-cycle misaligned-target exception pulse.
- badvaddr_o  out  ADDR_W  offending target; valid while adel_o = 1.

## Operation
- FSM states: RST, RUN, DRAIN.
- RST: ce=0, if_req=0, pc=INIT_PC. On the first edge with cpu_rst_n=1: go to RUN, ce=1.
- RUN: if_req=1. Fetch is consumed on an edge where if_ack=1 and stall[0]=0. Otherwise pc holds.
- Next pc on consume, by priority:
  - cp0_branch_flag: cp0_branch_addr.
  - branch_flag_i: branch_target_address_i.
  - Pending branch: pend_addr, then clear pend_v.
  - Otherwise pc + 4*FETCH_N, modulo 2^ADDR_W.
- branch_flag_i without a consume: latch pend_addr and set pend_v. A newer branch overwrites the pending one.
- cp0_branch_flag in RUN:
  - With if_ack=1: pc <= cp0_branch_addr on that edge, whatever stall[0] is.
  - Otherwise: latch cp0_addr, clear pend_v, go to DRAIN.
- DRAIN: if_req=1, pc held, inst_valid_o=0. stall[0] is ignored.
  - On if_ack=1: pc <= cp0_addr, go to RUN.
  - A further cp0_branch_flag in DRAIN overwrites cp0_addr.
  - branch_flag_i in DRAIN is dropped.
- inst_valid_o = if_ack & (state==RUN) & ~cp0_branch_flag. This is combinational and consumed only when stall[0]=0.

## Timing
- Reset values: pc=INIT_PC, ce=0, if_req=0, adel_o=0, badvaddr_o=0, pend_v=0, state=RST.
- First fetch of INIT_PC: if_req rises 1 cycle after reset is released.
- Zero-wait memory (if_ack tied 1, no stall): one fetch per cycle. Redirect latency is 1 cycle from a flag to the new pc.
- An N-cycle memory adds N-1 cycles per fetch. pc is guaranteed unchanged from if_req rising until the consuming edge.
- Reset asserted in any state (including DRAIN with pending): all state goes to reset values on that edge, and the outstanding response is discarded.
- Wrap-around: 0xFFFF_FFFC + 4 = 0x0000_0000; no flag is raised.
- Simultaneous cp0_branch_flag and branch_flag_i: CP0 wins, and the branch is discarded (not latched).

## Configuration
- PCGEN_ALIGN_CHECK_EN defined:
  - A branch target with [1:0] != 0 is neither followed nor latched; the sequential/pending path is used instead.
  - adel_o pulses 1 the cycle after the flag, with badvaddr_o = target.
  - CP0 targets are not checked.
- PCGEN_ALIGN_CHECK_EN undefined:
  - Targets are used as given.
  - adel_o and badvaddr_o are tied to 0, and the check logic is absent.

## Test plan
- Reset release, if_ack=1, stall=0: pc = BFC00000, BFC00004, BFC00008 on consecutive cycles; ce=1 from cycle 1.
- if_ack delayed 3 cycles: pc holds BFC00000 for 3 cycles with if_req=1, then becomes BFC00004.
- branch_flag_i=1 to 0x80001000 while stall[0]=1 for 2 cycles: pc holds; on the first unstalled ack pc = 0x80001000.
- cp0_branch_flag to 0xBFC00380 with no ack: DRAIN is entered and inst_valid_o=0; on the next if_ack, pc = 0xBFC00380 and the response is squashed.
- Simultaneous CP0 (0x80000180) and branch (0x80002000) with ack: pc = 0x80000180 and pend_v = 0. Reset asserted during DRAIN: pc = BFC00000 and ce = 0.
- ALIGN_CHECK_EN, branch target 0x80001002: pc = pc+4, adel_o=1 for 1 cycle, badvaddr_o = 0x80001002.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - MiniMIPS32 IF fetch-address generator with req/ack memory handshake and buffered redirects.
// Optional misaligned-branch check enabled by defining PCGEN_ALIGN_CHECK_EN.
module pc_gen #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] INIT_PC = 32'hBFC0_0000,
   parameter int                FETCH_N = 1,
   parameter int                STALL_W = 6
) (
   input  logic              cpu_clk_75M,
   input  logic              cpu_rst_n,
   input  logic [STALL_W-1:0] stall,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   input  logic              cp0_branch_flag,
   input  logic [ADDR_W-1:0] cp0_branch_addr,
   input  logic              if_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              if_req,
   output logic              inst_valid_o,
   output logic              adel_o,
   output logic [ADDR_W-1:0] badvaddr_o
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4 * FETCH_N);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic              pend_v, pend_v_nxt;
   logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
   logic [ADDR_W-1:0] cp0_addr, cp0_addr_nxt;
   logic              consume;
   logic              br_bad;
   logic              br_take;
   logic              unused_stall;

   assign unused_stall = ^stall;

`ifdef PCGEN_ALIGN_CHECK_EN
   assign br_bad = branch_flag_i & (branch_target_address_i[1:0] != 2'b00);
`else
   assign br_bad = 1'b0;
`endif
   assign br_take = branch_flag_i & ~br_bad;
   assign consume = if_ack & ~stall[0];

   assign ce           = (state != ST_RST);
   assign if_req       = (state != ST_RST);
   assign inst_valid_o = if_ack & (state == ST_RUN) & ~cp0_branch_flag;

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      pend_v_nxt    = pend_v;
      pend_addr_nxt = pend_addr;
      cp0_addr_nxt  = cp0_addr;
      case (state)
         ST_RST: state_nxt = ST_RUN;
         ST_RUN: begin
            // CP0 redirect flushes any buffered branch; with an ack it ignores stall.
            if (cp0_branch_flag) begin
               pend_v_nxt = 1'b0;
               if (if_ack) begin
                  pc_nxt = cp0_branch_addr;
               end else begin
                  cp0_addr_nxt = cp0_branch_addr;
                  state_nxt    = ST_DRAIN;
               end
            end else if (consume) begin
               pend_v_nxt = 1'b0;
               if (br_take)     pc_nxt = branch_target_address_i;
               else if (pend_v) pc_nxt = pend_addr;
               else             pc_nxt = pc + STEP;
            end else if (br_take) begin
               pend_v_nxt    = 1'b1;
               pend_addr_nxt = branch_target_address_i;
            end
         end
         ST_DRAIN: begin
            if (cp0_branch_flag) cp0_addr_nxt = cp0_branch_addr;
            if (if_ack) begin
               pc_nxt    = cp0_addr_nxt;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RST;
      endcase
   end

   always_ff @(posedge cpu_clk_75M) begin
      if (!cpu_rst_n) begin
         state     <= ST_RST;
         pc        <= INIT_PC;
         pend_v    <= 1'b0;
         pend_addr <= '0;
         cp0_addr  <= '0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         pend_v    <= pend_v_nxt;
         pend_addr <= pend_addr_nxt;
         cp0_addr  <= cp0_addr_nxt;
      end
   end

`ifdef PCGEN_ALIGN_CHECK_EN
   logic adel_nxt;

   // A dropped misaligned branch only counts when it would have been considered.
   assign adel_nxt = (state == ST_RUN) & br_bad & ~cp0_branch_flag;

   always_ff @(posedge cpu_clk_75M) begin
      if (!cpu_rst_n) begin
         adel_o     <= 1'b0;
         badvaddr_o <= '0;
      end else begin
         adel_o     <= adel_nxt;
         badvaddr_o <= adel_nxt ? branch_target_address_i : '0;
      end
   end
`else
   assign adel_o     = 1'b0;
   assign badvaddr_o = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen: directed plan steps plus randomized traffic against a reference model.
module tb_pc_gen;
   localparam logic [31:0] INIT = 32'hBFC0_0000;
   localparam int M_RST = 0, M_RUN = 1, M_DRAIN = 2;

   logic        cpu_clk_75M = 1'b0;
   logic        cpu_rst_n;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic        cp0_branch_flag;
   logic [31:0] cp0_branch_addr;
   logic        if_ack;
   logic [31:0] pc;
   logic        ce;
   logic        if_req;
   logic        inst_valid_o;
   logic        adel_o;
   logic [31:0] badvaddr_o;

   always #5 cpu_clk_75M = ~cpu_clk_75M;

   pc_gen #(.ADDR_W(32), .INIT_PC(INIT), .FETCH_N(1), .STALL_W(6)) dut (
      .cpu_clk_75M(cpu_clk_75M), .cpu_rst_n(cpu_rst_n), .stall(stall),
      .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
      .cp0_branch_flag(cp0_branch_flag), .cp0_branch_addr(cp0_branch_addr),
      .if_ack(if_ack), .pc(pc), .ce(ce), .if_req(if_req),
      .inst_valid_o(inst_valid_o), .adel_o(adel_o), .badvaddr_o(badvaddr_o)
   );

   int n_pass = 0;
   int n_total = 0;

   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_cp0;
   logic [31:0] pend_q[$];
   logic        m_adel;
   logic [31:0] m_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic bit aligned(input logic [31:0] a);
`ifdef PCGEN_ALIGN_CHECK_EN
      return (a % 4) == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      m_mode = M_RST;
      m_pc   = INIT;
      m_cp0  = 32'h0;
      pend_q.delete();
      m_adel = 1'b0;
      m_bad  = 32'h0;
   endtask

   // Advance the reference by one clock edge given the inputs presented during the cycle.
   task automatic model_edge(input logic rst_n, input logic st0, input logic bf, input logic [31:0] bt,
                             input logic cf, input logic [31:0] ca, input logic ack);
      bit follow = bf && aligned(bt);
      m_adel = 1'b0;
      m_bad  = 32'h0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_mode == M_RST) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (cf) begin
            pend_q.delete();
            if (ack) m_pc = ca;
            else begin
               m_cp0  = ca;
               m_mode = M_DRAIN;
            end
         end else begin
            if (bf && !aligned(bt)) begin
               m_adel = 1'b1;
               m_bad  = bt;
            end
            if (ack && !st0) begin
               if (follow) m_pc = bt;
               else if (pend_q.size() > 0) m_pc = pend_q.pop_front();
               else m_pc = m_pc + 32'd4;
               pend_q.delete();
            end else if (follow) begin
               pend_q = {bt};
            end
         end
      end else begin
         if (cf) m_cp0 = ca;
         if (ack) begin
            m_pc   = m_cp0;
            m_mode = M_RUN;
         end
      end
   endtask

   task automatic step(input logic rst_n, input logic [5:0] st, input logic bf, input logic [31:0] bt,
                       input logic cf, input logic [31:0] ca, input logic ack);
      cpu_rst_n = rst_n; stall = st; branch_flag_i = bf; branch_target_address_i = bt;
      cp0_branch_flag = cf; cp0_branch_addr = ca; if_ack = ack;
      #1;
      chk("pc", pc, m_pc);
      chk("ce", {31'b0, ce}, {31'b0, m_mode != M_RST});
      chk("if_req", {31'b0, if_req}, {31'b0, m_mode != M_RST});
      chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, ack && m_mode == M_RUN && !cf});
      model_edge(rst_n, st[0], bf, bt, cf, ca, ack);
      @(posedge cpu_clk_75M);
      #1;
      chk("adel", {31'b0, adel_o}, {31'b0, m_adel});
      chk("badvaddr", badvaddr_o, m_bad);
   endtask

   initial begin
      logic [31:0] bt;
      logic [31:0] ca;
      cpu_rst_n = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_address_i = '0;
      cp0_branch_flag = 1'b0; cp0_branch_addr = '0; if_ack = 1'b0;
      @(posedge cpu_clk_75M);
      #1;
      model_reset();

      // Reset state and boot sequence
      step(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("rst_pc", pc, INIT);
      chk("rst_ce", {31'b0, ce}, 32'h0);
      chk("rst_adel", {31'b0, adel_o}, 32'h0);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("boot_ce", {31'b0, ce}, 32'h1);
      chk("boot_pc0", pc, 32'hBFC0_0000);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("boot_pc1", pc, 32'hBFC0_0004);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("boot_pc2", pc, 32'hBFC0_0008);

      // Slow memory: pc held while waiting
      repeat (3) step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("slow_hold", pc, 32'hBFC0_0008);
      chk("slow_req", {31'b0, if_req}, 32'h1);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("slow_adv", pc, 32'hBFC0_000C);

      // Branch during stall is buffered
      repeat (2) step(1'b1, 6'h1, 1'b1, 32'h8000_1000, 1'b0, 32'h0, 1'b1);
      chk("stall_hold", pc, 32'hBFC0_000C);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("pend_taken", pc, 32'h8000_1000);

      // CP0 redirect without ack drains, then squashes
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b0);
      if_ack = 1'b1;
      #1;
      chk("drain_squash", {31'b0, inst_valid_o}, 32'h0);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("drain_pc", pc, 32'hBFC0_0380);

      // CP0 beats simultaneous branch; branch not latched
      step(1'b1, 6'h0, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_0180, 1'b1);
      chk("cp0_win", pc, 32'h8000_0180);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("no_pend", pc, 32'h8000_0184);

      // Reset in DRAIN with a pending branch
      step(1'b1, 6'h1, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 1'b0);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b0);
      step(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("drain_rst_pc", pc, INIT);
      chk("drain_rst_ce", {31'b0, ce}, 32'h0);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // Wrap-around
      step(1'b1, 6'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("wrap", pc, 32'h0000_0000);

`ifdef PCGEN_ALIGN_CHECK_EN
      step(1'b1, 6'h0, 1'b1, 32'h8000_1002, 1'b0, 32'h0, 1'b1);
      chk("align_pc", pc, 32'h0000_0004);
      chk("align_adel", {31'b0, adel_o}, 32'h1);
      chk("align_bad", badvaddr_o, 32'h8000_1002);
      step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("align_pulse", {31'b0, adel_o}, 32'h0);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bt = $urandom;
         ca = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(3) != 0) bt = bt & 32'hFFFF_FFFC;
         step(($urandom_range(63) != 0), 6'($urandom_range(3) == 0 ? 1 : 0) | 6'($urandom & 32'h3E),
              ($urandom_range(4) == 0), bt, ($urandom_range(11) == 0), ca, ($urandom_range(1) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
